// File: rtl/mem_access_unit.sv
// Memory-stage responder: runs one latched doubleword load/store on the data-memory
// request/response bus and reports completion, misalignment and bus timeout.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dm_re,
  input  logic        dm_we,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic        memu_valid,
  output logic        memu_finish,
  output logic [63:0] rdata,
  output logic        misalign,
  output logic        bus_err,
  output logic        dreq_valid,
  output logic        dreq_write,
  output logic [63:0] dreq_addr,
  output logic [63:0] dreq_wdata,
  output logic [7:0]  dreq_strb,
  input  logic        dreq_ready,
  input  logic        dresp_valid,
  input  logic [63:0] dresp_data
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t        state_reg;
  logic          write_reg;
  logic          misalign_reg;
  logic          bus_err_reg;
  logic [63:0]   addr_reg;
  logic [63:0]   wdata_reg;
  logic [63:0]   rdata_reg;
  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      write_reg    <= 1'b0;
      misalign_reg <= 1'b0;
      bus_err_reg  <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      count_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (dm_re || dm_we) begin
            addr_reg     <= addr;
            wdata_reg    <= wdata;
            write_reg    <= dm_we;
            misalign_reg <= (addr[2:0] != 3'b000);
            bus_err_reg  <= 1'b0;
            count_reg    <= '0;
            state_reg    <= (addr[2:0] == 3'b000) ? REQ : DONE;
          end
        end
        REQ: begin
          if (count_reg != CNT_MAX) count_reg <= count_reg + CW'(1);
          if (dreq_ready) begin
            state_reg <= RESP;
          end else if (count_reg == CNT_MAX) begin
            bus_err_reg <= 1'b1;
            state_reg   <= DONE;
          end
        end
        RESP: begin
          if (count_reg != CNT_MAX) count_reg <= count_reg + CW'(1);
          // A response landing on the timeout cycle still counts as success.
          if (dresp_valid) begin
            if (!write_reg) rdata_reg <= dresp_data;
            state_reg <= DONE;
          end else if (count_reg == CNT_MAX) begin
            bus_err_reg <= 1'b1;
            state_reg   <= DONE;
          end
        end
        DONE: begin
          if (memu_valid) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign memu_finish = (state_reg == DONE) && memu_valid;
  assign misalign    = memu_finish && misalign_reg;
  assign bus_err     = memu_finish && bus_err_reg;
  assign rdata       = rdata_reg;
  assign dreq_valid  = (state_reg == REQ);
  assign dreq_write  = dreq_valid && write_reg;
  assign dreq_strb   = (dreq_valid && write_reg) ? 8'hFF : 8'h00;
  assign dreq_addr   = addr_reg;
  assign dreq_wdata  = wdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: per-transaction cycle model checked every cycle,
// plus literal pins and a separate short-timeout instance.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst, dm_re, dm_we, memu_valid, dreq_ready, dresp_valid;
  logic [63:0] addr, wdata, dresp_data;
  logic        memu_finish, misalign, bus_err, dreq_valid, dreq_write;
  logic [63:0] rdata, dreq_addr, dreq_wdata;
  logic [7:0]  dreq_strb;

  logic        t_rst, t_dm_re, t_dm_we, t_memu_valid, t_dreq_ready, t_dresp_valid;
  logic [63:0] t_addr, t_wdata, t_dresp_data;
  logic        t_memu_finish, t_misalign, t_bus_err, t_dreq_valid, t_dreq_write;
  logic [63:0] t_rdata, t_dreq_addr, t_dreq_wdata;
  logic [7:0]  t_dreq_strb;

  int n_cmp = 0;
  int n_bad = 0;
  int cur_k = 0;
  int fin_seen_k = -1;
  bit chk_en = 1'b0;

  // expected outputs for the current cycle
  logic        exp_finish = 1'b0, exp_misalign = 1'b0, exp_dreq_valid = 1'b0, exp_write = 1'b0;
  logic [7:0]  exp_strb = 8'h00;
  logic [63:0] m_addr = '0, m_wdata = '0, m_rdata = '0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst), .dm_re(dm_re), .dm_we(dm_we), .addr(addr), .wdata(wdata),
    .memu_valid(memu_valid), .memu_finish(memu_finish), .rdata(rdata),
    .misalign(misalign), .bus_err(bus_err), .dreq_valid(dreq_valid),
    .dreq_write(dreq_write), .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata),
    .dreq_strb(dreq_strb), .dreq_ready(dreq_ready), .dresp_valid(dresp_valid),
    .dresp_data(dresp_data)
  );

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut_t (
    .clk(clk), .rst(t_rst), .dm_re(t_dm_re), .dm_we(t_dm_we), .addr(t_addr), .wdata(t_wdata),
    .memu_valid(t_memu_valid), .memu_finish(t_memu_finish), .rdata(t_rdata),
    .misalign(t_misalign), .bus_err(t_bus_err), .dreq_valid(t_dreq_valid),
    .dreq_write(t_dreq_write), .dreq_addr(t_dreq_addr), .dreq_wdata(t_dreq_wdata),
    .dreq_strb(t_dreq_strb), .dreq_ready(t_dreq_ready), .dresp_valid(t_dresp_valid),
    .dresp_data(t_dresp_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s k=%0d: got %h expected %h", name, cur_k, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("memu_finish", memu_finish, exp_finish);
      chk("misalign", misalign, exp_misalign);
      chk("bus_err", bus_err, 1'b0);
      chk("dreq_valid", dreq_valid, exp_dreq_valid);
      chk("dreq_write", dreq_write, exp_write);
      chk("dreq_strb", dreq_strb, exp_strb);
      chk("dreq_addr", dreq_addr, m_addr);
      chk("dreq_wdata", dreq_wdata, m_wdata);
      chk("rdata", rdata, m_rdata);
      if (memu_finish) fin_seen_k = cur_k;
      $display("k=%0d fin=%b mis=%b req=%b wr=%b addr=%h rdata=%h", cur_k, memu_finish,
               misalign, dreq_valid, dreq_write, dreq_addr, rdata);
    end
  end

  // One access: strobe in cycle 0, W ready-wait cycles, R response-wait cycles,
  // memu_valid low before cycle gate, optional reset pulse in cycle rst_at (>0).
  task automatic run_txn(input bit wr, input bit rd, input logic [63:0] a, input logic [63:0] wd,
                         input int w, input int r, input logic [63:0] rsp, input int gate,
                         input int rst_at);
    bit mis;
    bit aborted;
    int fin;
    int last;
    mis = (a[2:0] != 3'b000);
    fin = mis ? 1 : 3 + w + r;
    if (gate > fin) fin = gate;
    if (rst_at > 0) fin = -1;
    last = (rst_at > 0) ? rst_at + 5 : fin + 1;
    fin_seen_k = -1;
    for (int k = 0; k <= last; k++) begin
      cur_k = k;
      dm_re = (k == 0) && rd;
      dm_we = (k == 0) && wr;
      addr = a;
      wdata = wd;
      memu_valid = (k >= gate);
      dreq_ready = (k >= 1 + w);
      dresp_valid = !mis && (k == 2 + w + r);
      dresp_data = (k == 2 + w + r) ? rsp : ~rsp;
      rst = (rst_at > 0) && (k == rst_at);
      aborted = (rst_at > 0) && (k > rst_at);
      if (k == 1) begin
        m_addr = a;
        m_wdata = wd;
      end
      if ((rst_at > 0) && (k == rst_at + 1)) begin
        m_addr = '0;
        m_wdata = '0;
        m_rdata = '0;
      end
      if (!mis && !wr && !aborted && (k == 3 + w + r)) m_rdata = rsp;
      exp_dreq_valid = !mis && !aborted && (k >= 1) && (k <= 1 + w);
      exp_write = exp_dreq_valid && wr;
      exp_strb = exp_write ? 8'hFF : 8'h00;
      exp_finish = (k == fin);
      exp_misalign = exp_finish && mis;
      @(posedge clk);
      #1;
    end
    $display("txn addr=%h wr=%b w=%0d r=%0d gate=%0d rst_at=%0d finish_k=%0d", a, wr, w, r,
             gate, rst_at, fin_seen_k);
  endtask

  initial begin
    rst = 1'b1; dm_re = 1'b0; dm_we = 1'b0; addr = '0; wdata = '0; memu_valid = 1'b1;
    dreq_ready = 1'b0; dresp_valid = 1'b0; dresp_data = '0;
    t_rst = 1'b1; t_dm_re = 1'b0; t_dm_we = 1'b0; t_addr = '0; t_wdata = '0;
    t_memu_valid = 1'b1; t_dreq_ready = 1'b0; t_dresp_valid = 1'b0; t_dresp_data = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    t_rst = 1'b0;

    // aligned zero-wait load, then stalled store that must not touch rdata
    run_txn(1'b0, 1'b1, 64'h80000010, 64'h0, 0, 0, 64'hDEADBEEF_01234567, 0, 0);
    chk("pin_load_fin", fin_seen_k, 3);
    chk("pin_load_rdata", rdata, 64'hDEADBEEF_01234567);
    run_txn(1'b1, 1'b0, 64'h1000, 64'h55AA, 2, 3, 64'hBAD0BAD0, 0, 0);
    chk("pin_store_fin", fin_seen_k, 8);
    chk("pin_store_rdata", rdata, 64'hDEADBEEF_01234567);

    // misaligned load
    run_txn(1'b0, 1'b1, 64'h1004, 64'h0, 0, 0, 64'h9999, 0, 0);
    chk("pin_mis_fin", fin_seen_k, 1);

    // reset during RESP, then a normal load with waits
    run_txn(1'b0, 1'b1, 64'h2000, 64'h0, 0, 3, 64'h1111, 0, 3);
    chk("pin_rst_nofin", fin_seen_k, -1);
    chk("pin_rst_rdata", rdata, 64'h0);
    run_txn(1'b0, 1'b1, 64'h2008, 64'h0, 1, 1, 64'h2222_3333, 0, 0);
    chk("pin_ld2_fin", fin_seen_k, 5);
    chk("pin_ld2_rdata", rdata, 64'h2222_3333);

    // both strobes: write wins
    run_txn(1'b1, 1'b1, 64'h3000, 64'hABCD, 0, 0, 64'h4444, 0, 0);
    chk("pin_both_fin", fin_seen_k, 3);
    chk("pin_both_rdata", rdata, 64'h2222_3333);

    // finish held off by memu_valid
    run_txn(1'b0, 1'b1, 64'h3008, 64'h0, 0, 0, 64'h77, 6, 0);
    chk("pin_gate_fin", fin_seen_k, 6);
    chk("pin_gate_rdata", rdata, 64'h77);

    // timeout on the short-timeout instance; late response in cycle 8 is ignored
    for (int k = 0; k <= 9; k++) begin
      cur_k = k;
      t_dm_re = (k == 0);
      t_addr = 64'h2000;
      t_dreq_ready = 1'b1;
      t_dresp_valid = (k == 8);
      t_dresp_data = 64'hFEED_F00D;
      @(negedge clk);
      chk("t_finish", t_memu_finish, (k == 6));
      chk("t_bus_err", t_bus_err, (k == 6));
      chk("t_dreq_valid", t_dreq_valid, (k == 1));
      chk("t_rdata", t_rdata, 64'h0);
      $display("timeout k=%0d fin=%b err=%b req=%b rdata=%h", k, t_memu_finish, t_bus_err,
               t_dreq_valid, t_rdata);
      @(posedge clk); #1;
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
